// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding ibus requests, and a small {pc,instr} buffer toward decode.
// Optional FETCH_BUF2_EN selects a 2-entry buffer (1 instr/cycle); otherwise a single head slot.

package fetch_unit_pkg;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_raw_instr,
    output logic [63:0] dec_pc
);

`ifdef FETCH_BUF2_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic         ireq_valid_d;
    logic         head_valid_d;
    fetch_entry_t head_d;
    fetch_entry_t new_entry;
    logic [OCC_W-1:0] occ_q, occ_after;
    logic         req_active, accept, resp, push, pop, free_after;

`ifdef FETCH_BUF2_EN
    logic         tail_valid_q, tail_valid_d;
    fetch_entry_t tail_q, tail_d;
    assign occ_q = OCC_W'(dec_valid) + OCC_W'(tail_valid_q);
`else
    assign occ_q = OCC_W'(dec_valid);
`endif

    assign ireq_addr  = pc_q;
    assign new_entry  = {pc_q, iresp_data};
    // The request is only live once ireq_valid is actually presented on the bus.
    assign req_active = (state_q == ST_REQ) && ireq_valid;
    assign accept     = req_active && iresp_addr_ok;
    assign resp       = ((state_q == ST_WAIT) || accept) && iresp_data_ok;
    assign push       = resp && !drop_q && !redirect_valid;
    assign pop        = dec_valid && dec_ready && !redirect_valid;
    assign occ_after  = occ_q + OCC_W'(push) - OCC_W'(pop);
    assign free_after = occ_after < OCC_W'(DEPTH);

    // Next-state, PC and drop tracking; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~64'd3;
            unique case (state_q)
                ST_REQ: begin
                    if (accept && !iresp_data_ok) begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (iresp_data_ok) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (accept) begin
                        if (iresp_data_ok) begin
                            pc_d    = pc_q + 64'd4;
                            state_d = free_after ? ST_REQ : ST_HOLD;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (iresp_data_ok) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            pc_d    = pc_q + 64'd4;
                            state_d = free_after ? ST_REQ : ST_HOLD;
                        end
                    end
                end
                default: begin
                    if (pop) state_d = ST_REQ;
                end
            endcase
        end
        ireq_valid_d = (state_d == ST_REQ);
    end

    // Buffer update: head feeds decode directly, tail (if present) refills it in order.
    always_comb begin
        head_valid_d = dec_valid;
        head_d       = {dec_pc, dec_raw_instr};
`ifdef FETCH_BUF2_EN
        tail_valid_d = tail_valid_q;
        tail_d       = tail_q;
`endif
        if (redirect_valid) begin
            head_valid_d = 1'b0;
`ifdef FETCH_BUF2_EN
            tail_valid_d = 1'b0;
`endif
        end else begin
            if (pop) begin
`ifdef FETCH_BUF2_EN
                if (tail_valid_q) begin
                    head_d       = tail_q;
                    tail_valid_d = 1'b0;
                end else begin
                    head_valid_d = 1'b0;
                end
`else
                head_valid_d = 1'b0;
`endif
            end
            if (push) begin
                if (!head_valid_d) begin
                    head_valid_d = 1'b1;
                    head_d       = new_entry;
                end
`ifdef FETCH_BUF2_EN
                else begin
                    tail_valid_d = 1'b1;
                    tail_d       = new_entry;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_REQ;
            pc_q          <= PC_RESET;
            drop_q        <= 1'b0;
            ireq_valid    <= 1'b0;
            dec_valid     <= 1'b0;
            dec_pc        <= '0;
            dec_raw_instr <= '0;
`ifdef FETCH_BUF2_EN
            tail_valid_q  <= 1'b0;
            tail_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            ireq_valid    <= ireq_valid_d;
            dec_valid     <= head_valid_d;
            dec_pc        <= head_d.pc;
            dec_raw_instr <= head_d.instr;
`ifdef FETCH_BUF2_EN
            tail_valid_q  <= tail_valid_d;
            tail_q        <= tail_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable ibus responder pushes expected
// {pc,instr} on every accepted request; decode-side output is checked against the queue head.
module tb_fetch_unit;

    localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
`ifdef FETCH_BUF2_EN
    localparam int EXP_STREAM = 20;
`else
    localparam int EXP_STREAM = 10;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } sb_item_t;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_raw_instr;
    logic [63:0] dec_pc;

    fetch_unit #(.PC_RESET(PC_RESET)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_raw_instr (dec_raw_instr),
        .dec_pc        (dec_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    sb_item_t    sb_q[$];
    logic [63:0] exp_fetch_pc = PC_RESET;

    // responder and stimulus knobs
    int          bus_lat       = 1;
    bit          bus_en        = 1'b1;
    bit          ready_knob    = 1'b0;
    bit          redir_now     = 1'b0;
    bit          redir_on_data = 1'b0;
    bit          redir_in_wait = 1'b0;
    bit          redir_fired   = 1'b0;
    bit          stale_ret     = 1'b0;
    logic [63:0] redir_target  = '0;
    bit          outst         = 1'b0;
    bit          out_stale     = 1'b0;
    int          cnt           = 0;
    logic [63:0] out_addr      = '0;
    int          nvalid        = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_fn(input logic [63:0] a);
        if (a == PC_RESET) return 32'h0000_0013;
        return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F01;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Observe the current cycle's outputs and choose inputs for the next rising edge.
    task automatic drive();
        logic        do_redir, a_ok, d_ok;
        logic [31:0] rdata;
        sb_item_t    it;
        do_redir = redir_now;
        a_ok     = 1'b0;
        d_ok     = 1'b0;
        rdata    = '0;
        if (outst) begin
            check("single_outstanding", 64'(ireq_valid), 64'(0));
            cnt = cnt - 1;
            if (redir_in_wait && cnt == 3) begin
                do_redir      = 1'b1;
                redir_in_wait = 1'b0;
            end
            if (cnt == 0) begin
                d_ok  = 1'b1;
                rdata = out_stale ? 32'hDEAD_BEEF : data_fn(out_addr);
                if (out_stale) stale_ret = 1'b1;
                if (redir_on_data) begin
                    do_redir      = 1'b1;
                    redir_on_data = 1'b0;
                end
                outst = 1'b0;
            end
        end else if (ireq_valid && bus_en) begin
            a_ok = 1'b1;
            check("req_addr", ireq_addr, exp_fetch_pc);
            if (bus_lat == 0) begin
                d_ok  = 1'b1;
                rdata = data_fn(ireq_addr);
                if (redir_on_data) begin
                    do_redir      = 1'b1;
                    redir_on_data = 1'b0;
                end
            end else begin
                outst     = 1'b1;
                out_stale = 1'b0;
                cnt       = bus_lat;
                out_addr  = ireq_addr;
            end
            if (!do_redir) begin
                it.pc    = exp_fetch_pc;
                it.instr = data_fn(exp_fetch_pc);
                sb_q.push_back(it);
                exp_fetch_pc = exp_fetch_pc + 64'd4;
            end
        end
        if (dec_valid) begin
            nvalid++;
            check("dec_has_expected", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                check("dec_pc", dec_pc, sb_q[0].pc);
                check("dec_instr", 64'(dec_raw_instr), 64'(sb_q[0].instr));
                if (ready_knob && !do_redir) void'(sb_q.pop_front());
            end
        end
        if (do_redir) begin
            sb_q.delete();
            exp_fetch_pc = redir_target & ~64'd3;
            if (outst) out_stale = 1'b1;
            redir_fired = 1'b1;
        end
        redir_now      = 1'b0;
        iresp_addr_ok  = a_ok;
        iresp_data_ok  = d_ok;
        iresp_data     = rdata;
        dec_ready      = ready_knob;
        redirect_valid = do_redir;
        redirect_pc    = redir_target;
    endtask

    task automatic step();
        tick();
        drive();
    endtask

    task automatic set_lat(input int l);
        int n = 0;
        while (outst && n < 20) begin
            step();
            n++;
        end
        check("bus_idle_timeout", 64'(outst), 64'(0));
        bus_lat = l;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset          = 1'b0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;

        // reset values, then first request and first delivered word
        repeat (3) @(negedge clk);
        check("rst_ireq_valid", 64'(ireq_valid), 64'(0));
        check("rst_dec_valid", 64'(dec_valid), 64'(0));
        check("rst_dec_pc", dec_pc, 64'(0));
        check("rst_dec_instr", 64'(dec_raw_instr), 64'(0));
        reset = 1'b1;
        tick();
        check("rel_ireq_valid", 64'(ireq_valid), 64'(1));
        check("rel_ireq_addr", ireq_addr, PC_RESET);
        drive();
        step();
        tick();
        check("first_dec_valid", 64'(dec_valid), 64'(1));
        check("first_dec_pc", dec_pc, PC_RESET);
        check("first_dec_instr", 64'(dec_raw_instr), 64'h13);
        drive();
        ready_knob = 1'b1;
        repeat (6) step();

        // streaming on a zero-latency bus
        set_lat(0);
        repeat (6) step();
        nvalid = 0;
        repeat (20) step();
        check("stream_rate", 64'(nvalid), 64'(EXP_STREAM));

        // backpressure
        set_lat(1);
        ready_knob = 1'b0;
        repeat (10) step();
        tick();
        check("bp_hold_no_req", 64'(ireq_valid), 64'(0));
        check("bp_head_valid", 64'(dec_valid), 64'(1));
        drive();
        ready_knob = 1'b1;
        repeat (12) step();

        // stale response after redirect in WAIT
        set_lat(4);
        redir_target  = 64'h0000_0000_8000_1002;
        stale_ret     = 1'b0;
        redir_in_wait = 1'b1;
        n = 0;
        while (!stale_ret && n < 40) begin
            step();
            n++;
        end
        check("stale_seen", 64'(stale_ret), 64'(1));
        tick();
        check("stale_next_req", 64'(ireq_valid), 64'(1));
        check("stale_next_addr", ireq_addr, 64'h0000_0000_8000_1000);
        drive();
        repeat (10) step();

        // redirect together with data_ok and dec_ready
        set_lat(2);
        redir_target  = 64'h0000_0000_8000_2000;
        redir_fired   = 1'b0;
        redir_on_data = 1'b1;
        n = 0;
        while (!redir_fired && n < 40) begin
            step();
            n++;
        end
        check("simul_fired", 64'(redir_fired), 64'(1));
        tick();
        check("simul_dec_empty", 64'(dec_valid), 64'(0));
        check("simul_req_valid", 64'(ireq_valid), 64'(1));
        check("simul_req_addr", ireq_addr, 64'h0000_0000_8000_2000);
        drive();
        repeat (8) step();

        // PC wrap across 2^64
        set_lat(0);
        redir_target = 64'hFFFF_FFFF_FFFF_FFF8;
        redir_now    = 1'b1;
        step();
        repeat (10) step();

        // asynchronous reset while a transaction is in flight
        set_lat(6);
        n = 0;
        while (!outst && n < 20) begin
            step();
            n++;
        end
        check("mid_wait_reached", 64'(outst), 64'(1));
        step();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_ireq_valid", 64'(ireq_valid), 64'(0));
        check("async_dec_valid", 64'(dec_valid), 64'(0));
        check("async_dec_pc", dec_pc, 64'(0));
        check("async_dec_instr", 64'(dec_raw_instr), 64'(0));
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        redirect_valid = 1'b0;
        outst          = 1'b0;
        sb_q.delete();
        exp_fetch_pc   = PC_RESET;
        bus_lat        = 1;
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("restart_req_valid", 64'(ireq_valid), 64'(1));
        check("restart_req_addr", ireq_addr, PC_RESET);
        drive();
        repeat (8) step();

        // drain everything outstanding
        bus_en = 1'b0;
        n = 0;
        while ((sb_q.size() != 0 || outst) && n < 60) begin
            step();
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
